// File: rtl/g1_pkg.sv
// Shared constants and per-bit debounce state type for the g1 input front end.
package g1_pkg;

    localparam int G1_NBITS    = 4;
    localparam int G1_DB_CNT_W = 8;

    typedef enum logic {
        G1_ST_STABLE   = 1'b0,
        G1_ST_COUNTING = 1'b1
    } g1_db_st_e;

endpackage

// File: rtl/g1_db_bit.sv
// One input line: optional 2-flop synchronizer (G1_SYNC_EN) followed by the
// per-bit debounce FSM. upd_o is high on the edge where x_o will take a new value.
module g1_db_bit
    import g1_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic x_o,
    output logic upd_o,
    output logic cnt_nz_o
);

    localparam logic [G1_DB_CNT_W-1:0] DB_LAST = G1_DB_CNT_W'(DB_CYCLES - 1);

    logic w_s;

`ifdef G1_SYNC_EN
    logic r_sync_p0;
    logic r_sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= raw_i;
            r_sync_p1 <= r_sync_p0;
        end
    end

    assign w_s = r_sync_p1;
`else
    assign w_s = raw_i;
`endif

    g1_db_st_e              r_state;
    logic [G1_DB_CNT_W-1:0] r_cnt;
    logic                   r_x;
    logic                   w_diff;
    logic                   w_upd;

    assign w_diff = (w_s != r_x);
    // A single-cycle debounce commits straight from STABLE; otherwise only the last count commits.
    assign w_upd  = w_diff && (((r_state == G1_ST_STABLE) && (DB_CYCLES == 1)) ||
                               ((r_state == G1_ST_COUNTING) && (r_cnt == DB_LAST)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= G1_ST_STABLE;
            r_cnt   <= '0;
            r_x     <= 1'b0;
        end else begin
            case (r_state)
                G1_ST_STABLE: begin
                    if (w_upd) begin
                        r_x <= w_s;
                    end else if (w_diff) begin
                        r_state <= G1_ST_COUNTING;
                        r_cnt   <= G1_DB_CNT_W'(1);
                    end
                end
                G1_ST_COUNTING: begin
                    if (!w_diff || w_upd) begin
                        r_state <= G1_ST_STABLE;
                        r_cnt   <= '0;
                        if (w_upd) begin
                            r_x <= w_s;
                        end
                    end else begin
                        r_cnt <= r_cnt + G1_DB_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= G1_ST_STABLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign x_o      = r_x;
    assign upd_o    = w_upd;
    assign cnt_nz_o = (r_cnt != '0);

endmodule

// File: rtl/g1_input_debounce.sv
// Four-line debounce front end for the g1 encoder x input; chg pulses once per
// update edge. Build macro G1_SYNC_EN inserts a 2-flop synchronizer per line.
module g1_input_debounce
    import g1_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [G1_NBITS-1:0] raw,
    output logic [G1_NBITS-1:0] x,
    output logic                chg,
    output logic                busy
);

    logic [G1_NBITS-1:0] w_upd;
    logic [G1_NBITS-1:0] w_cnt_nz;
    logic                r_chg;

    for (genvar gi = 0; gi < G1_NBITS; gi++) begin : g_bit
        g1_db_bit #(
            .DB_CYCLES(DB_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (raw[gi]),
            .x_o      (x[gi]),
            .upd_o    (w_upd[gi]),
            .cnt_nz_o (w_cnt_nz[gi])
        );
    end

    // Registered alongside x so the pulse lands on the same edge as the new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chg <= 1'b0;
        end else begin
            r_chg <= |w_upd;
        end
    end

    assign chg  = r_chg;
    assign busy = |w_cnt_nz;

endmodule

// File: tb/tb_g1_input_debounce.sv
// Randomized bench for g1_input_debounce against a sample-window reference model.
module tb_g1_input_debounce;

    localparam int DB = 4;
`ifdef G1_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] raw;
    logic [3:0] x;
    logic       chg;
    logic       busy;

    g1_input_debounce #(
        .DB_CYCLES(DB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw),
        .x    (x),
        .chg  (chg),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: raw samples per edge, sampled values seen by the debouncer.
    logic [3:0] q_raw[$];
    logic [3:0] q_s[$];
    logic [3:0] m_x;
    logic       m_chg;
    logic       m_busy;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q_raw.delete();
        q_s.delete();
        m_x    = 4'b0000;
        m_chg  = 1'b0;
        m_busy = 1'b0;
    endtask

    // A bit flips when the last DB sampled values all disagree with it; busy means
    // the newest sample disagrees with the word held after this edge.
    task automatic model_edge(input logic [3:0] r);
        logic [3:0] s;
        logic       all_diff;
        q_raw.push_back(r);
        if (q_raw.size() > LAT) s = q_raw[q_raw.size() - 1 - LAT];
        else                    s = 4'b0000;
        q_s.push_back(s);
        if (q_raw.size() > 64) void'(q_raw.pop_front());
        if (q_s.size() > 64)   void'(q_s.pop_front());
        m_chg  = 1'b0;
        m_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (q_s.size() >= DB) begin
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (q_s[q_s.size() - 1 - k][i] == m_x[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_x[i] = ~m_x[i];
                    m_chg  = 1'b1;
                end
            end
            if (s[i] != m_x[i]) m_busy = 1'b1;
        end
    endtask

    task automatic step(input logic [3:0] r);
        raw = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_eq("x", int'(x), int'(m_x));
        check_eq("chg", int'(chg), int'(m_chg));
        check_eq("busy", int'(busy), int'(m_busy));
    endtask

    // Asynchronous reset pulse landing mid-cycle, released on a falling edge.
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_eq("rst_x", int'(x), 0);
        check_eq("rst_chg", int'(chg), 0);
        check_eq("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_edge(raw);
        #1;
        check_eq("post_rst_x", int'(x), int'(m_x));
        check_eq("post_rst_busy", int'(busy), int'(m_busy));
    endtask

    int lat;
    int pulses;
    logic [3:0] r_val;
    int hold;

    initial begin
        rst = 1'b1;
        raw = 4'b1111;
        model_clear();

        // Reset held with all inputs high
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_eq("reset_x", int'(x), 0);
            check_eq("reset_chg", int'(chg), 0);
            check_eq("reset_busy", int'(busy), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        raw = 4'b0000;

        // Single update: latency from first edge holding the new value to chg
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            step(4'b1011);
            if (chg && lat < 0) lat = k;
        end
        check_eq("single_latency", lat, DB + LAT - 1);
        check_eq("single_x", int'(x), 11);

        // Glitch rejection on bit 0
        for (int k = 0; k < 8; k++) step(4'b0000);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin step(4'b0001); pulses += int'(chg); end
        for (int k = 0; k < 8; k++) begin step(4'b0000); pulses += int'(chg); end
        check_eq("glitch_pulses", pulses, 0);
        check_eq("glitch_x", int'(x), 0);
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            step(4'b0001);
            if (chg && lat < 0) lat = k;
        end
        check_eq("hold_latency", lat, DB + LAT - 1);

        // Multi-bit change gives one pulse
        for (int k = 0; k < 8; k++) step(4'b1011);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin step(4'b0101); pulses += int'(chg); end
        check_eq("multi_pulses", pulses, 1);
        check_eq("multi_x", int'(x), 5);

        // Reset mid-count, then the same value debounces again from scratch
        for (int k = 0; k < 8; k++) step(4'b0000);
        for (int k = 0; k < 3; k++) step(4'b1110);
        mid_reset();
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            step(4'b1110);
            if (chg && lat < 0) lat = k + 1;
        end
        check_eq("rst_recover_latency", lat, DB + LAT - 1);
        check_eq("rst_recover_x", int'(x), 14);

        // Randomized holds of varying length, with occasional resets
        for (int t = 0; t < 120; t++) begin
            r_val = 4'($urandom_range(0, 15));
            hold  = $urandom_range(1, DB + LAT + 2);
            for (int k = 0; k < hold; k++) begin
                if ($urandom_range(0, 3) == 0) r_val[$urandom_range(0, 3)] ^= 1'b1;
                step(r_val);
            end
            if ($urandom_range(0, 29) == 0) mid_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
